serial_alu_ctrl: RTL and testbench
==================================

# serial_alu_ctrl

Bit-serial MIPS ALU engine. It accepts one 32-bit ALU operation per handshake and decodes the 4-bit MIPS ALU-control code into per-bit slice controls (inva, invb, carry-in, 2-bit operation select, set). It then evaluates the operation one bit per clock, LSB first, through a single carry flip-flop and returns the word result with zero/overflow flags. It is the control/sequencing end of the one-bit ALU slice interface and sits between the multicycle datapath controller and the register-file write-back path.

## Interface
- WIDTH, 32, operand/result width in bits (≥2)
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- start  in  1  request; sampled only in IDLE
- aluop  in  4  MIPS ALU control: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR
- a, b  in  WIDTH  operands, sampled with start
- busy  out  1  high in RUN and FIN
- done  out  1  one-cycle pulse, result/flags valid
- result  out  WIDTH  registered result, held until next done
- zero  out  1  result == 0
- overflow  out  1  signed overflow (ADD/SUB/SLT only, else 0)
- illegal  out  1  aluop not in list above, valid with done

## Operation
- Decode (inva, invb, cin, sel): AND 0,0,0,00; OR 0,0,0,01; ADD 0,0,0,10; SUB 0,1,1,10; SLT 0,1,1,11; NOR 1,1,0,00.
- Illegal code: decode as AND with both operands forced to 0. result=0, zero=1, illegal=1.
- FSM: IDLE → (start) RUN → (cnt==WIDTH-1) FIN → DONE → IDLE. start outside IDLE is ignored, not queued.
- On accept: latch a, b, decoded controls. cnt=0, carry=cin.
- RUN, bit i=cnt per cycle:
  - ta=a[i]^inva, tb=b[i]^invb.
  - s=ta^tb^carry; cout=majority(ta,tb,carry).
  - f by sel: 00 ta&tb, 01 ta|tb, 10 s, 11 0 (set input is 0 for all bits in this pass).
  - f shifts into result shift register from MSB side. carry←cout, cnt++.
- At i=WIDTH-1: capture sgn=s and ovf=carry^cout.
- FIN: less = sgn^ovf. For SLT, result ← {0…0, less}. Register overflow (ovf for ADD/SUB/SLT, else 0) and zero.
- DONE: done=1 for exactly one cycle.
- Reset values: state IDLE, busy 0, done 0, result 0, zero 0, overflow 0, illegal 0, cnt 0, carry 0.
- Reset asserted mid-operation aborts immediately to reset values; no done is issued.

## Timing
- Accepting edge E0: start=1 in IDLE. Bits processed at edges E1..E_WIDTH.
- FIN completes at E_WIDTH+1. done high during the cycle after E_WIDTH+1, i.e. start-to-done is WIDTH+2 edges.
- Minimum start-to-start period is WIDTH+3 cycles, because a start seen during the DONE cycle is ignored.
- result/flags change only at the FIN→DONE edge. They are stable from done until the next done.
- Operand inputs may change freely after E0.
- cnt width is $clog2(WIDTH). There is no wrap; FIN is entered on cnt==WIDTH-1.

## Structure
- Package alu_pkg:
  - aluop code constants
  - sel encodings (SEL_AND, SEL_OR, SEL_ADD, SEL_SET)
  - state enum {IDLE, RUN, FIN, DONE}
  - decoded-control struct {inva, invb, cin, sel, illegal}
- Sub-module alu_op_decode: combinational aluop → control struct. The FSM, counter, carry and shift register stay in serial_alu_ctrl.

## Test plan
- ADD 0x7FFFFFFF + 0x00000001 → result 0x80000000, overflow=1, zero=0. done exactly 34 edges after accept.
- SUB 0x00000005 − 0x00000005 → result 0, zero=1, overflow=0. NOR 0,0 → 0xFFFFFFFF.
- SLT 0xFFFFFFFF vs 0x00000001 → result 1. SLT 0x7FFFFFFF vs 0x80000000 → result 0, overflow=1.
- AND 0xF0F0F0F0 & 0xFF00FF00 → 0xF000F000. OR → 0xFFF0FFF0. aluop 1111 → result 0, illegal=1, zero=1.
- start pulsed at cycles 5 and 20 after accept, and during DONE → ignored: single done, result of first op only.
- rst_n low at bit 10 of an ADD → all outputs 0 asynchronously, no done. Next start completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and constants for the bit-serial MIPS ALU engine:
// ALU-control codes, slice operation selects, FSM states and decoded controls.
package alu_pkg;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;

    localparam logic [1:0] SEL_AND = 2'b00;
    localparam logic [1:0] SEL_OR  = 2'b01;
    localparam logic [1:0] SEL_ADD = 2'b10;
    localparam logic [1:0] SEL_SET = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef struct packed {
        logic       inva;
        logic       invb;
        logic       cin;
        logic [1:0] sel;
        logic       illegal;
    } ctl_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational decode of the 4-bit MIPS ALU-control code into one-bit slice controls.
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [3:0] aluop,
    output ctl_t       ctl
);

    always_comb begin
        // Unknown codes behave as AND; the top forces the operands to zero.
        ctl = '{inva: 1'b0, invb: 1'b0, cin: 1'b0, sel: SEL_AND, illegal: 1'b1};
        case (aluop)
            OP_AND: ctl = '{inva: 1'b0, invb: 1'b0, cin: 1'b0, sel: SEL_AND, illegal: 1'b0};
            OP_OR:  ctl = '{inva: 1'b0, invb: 1'b0, cin: 1'b0, sel: SEL_OR,  illegal: 1'b0};
            OP_ADD: ctl = '{inva: 1'b0, invb: 1'b0, cin: 1'b0, sel: SEL_ADD, illegal: 1'b0};
            OP_SUB: ctl = '{inva: 1'b0, invb: 1'b1, cin: 1'b1, sel: SEL_ADD, illegal: 1'b0};
            OP_SLT: ctl = '{inva: 1'b0, invb: 1'b1, cin: 1'b1, sel: SEL_SET, illegal: 1'b0};
            OP_NOR: ctl = '{inva: 1'b1, invb: 1'b1, cin: 1'b0, sel: SEL_AND, illegal: 1'b0};
            default: ;
        endcase
    end

endmodule

// File: rtl/serial_alu_ctrl.sv
// Bit-serial ALU engine: one operand bit per clock, LSB first, through a single
// carry flip-flop; result and flags are registered once per operation.
module serial_alu_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       aluop,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             illegal
);

    localparam int CW = $clog2(WIDTH);

    state_t           state, state_nxt;
    ctl_t             dec;
    logic [WIDTH-1:0] a_r, b_r, sr;
    logic             inva_r, invb_r, ill_r;
    logic [1:0]       sel_r;
    logic [CW-1:0]    cnt;
    logic             carry, sgn, ovf;
    logic             last, ta, tb, s, cout, f, is_arith;
    logic [WIDTH-1:0] final_res;

    alu_op_decode u_decode (
        .aluop (aluop),
        .ctl   (dec)
    );

    assign last      = (cnt == CW'(WIDTH - 1));
    assign ta        = a_r[cnt] ^ inva_r;
    assign tb        = b_r[cnt] ^ invb_r;
    assign s         = ta ^ tb ^ carry;
    assign cout      = (ta & tb) | (ta & carry) | (tb & carry);
    assign is_arith  = (sel_r == SEL_ADD) || (sel_r == SEL_SET);
    assign final_res = (sel_r == SEL_SET) ? {{(WIDTH-1){1'b0}}, sgn ^ ovf} : sr;

    always_comb begin
        f = 1'b0;
        case (sel_r)
            SEL_AND: f = ta & tb;
            SEL_OR:  f = ta | tb;
            SEL_ADD: f = s;
            default: f = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = FIN;
            FIN:     state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN) || (state == FIN);
        done = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            carry    <= 1'b0;
            result   <= '0;
            zero     <= 1'b0;
            overflow <= 1'b0;
            illegal  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    cnt   <= '0;
                    carry <= dec.cin;
                end
                RUN: begin
                    carry <= cout;
                    cnt   <= last ? '0 : cnt + 1'b1;
                end
                FIN: begin
                    result   <= final_res;
                    zero     <= (final_res == '0);
                    overflow <= is_arith & ovf;
                    illegal  <= ill_r;
                end
                default: ;
            endcase
        end
    end

    // Operand, control and shift-register state needs no reset: it is fully
    // reloaded on every accept and overwritten over WIDTH RUN cycles.
    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            a_r    <= dec.illegal ? '0 : a;
            b_r    <= dec.illegal ? '0 : b;
            inva_r <= dec.inva;
            invb_r <= dec.invb;
            sel_r  <= dec.sel;
            ill_r  <= dec.illegal;
        end
        if (state == RUN) begin
            sr <= {f, sr[WIDTH-1:1]};
            if (last) begin
                sgn <= s;
                ovf <= carry ^ cout;
            end
        end
    end

endmodule

// File: tb/tb_serial_alu_ctrl.sv
// Self-checking bench for serial_alu_ctrl: directed vector table, multi-cycle
// corner sequences and randomized operations against a word-level model.
module tb_serial_alu_ctrl;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [3:0]   aluop = 4'b0;
    logic [W-1:0] a = '0, b = '0;
    logic         busy, done, zero, overflow, illegal;
    logic [W-1:0] result;

    int total = 0;
    int bad   = 0;

    serial_alu_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .aluop    (aluop),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .zero     (zero),
        .overflow (overflow),
        .illegal  (illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         z;
        logic         ovf;
        logic         ill;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Word-level reference: plain arithmetic on whole operands.
    task automatic model(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                         output logic [W-1:0] r, output logic z, output logic o, output logic il);
        logic [W-1:0] d;
        r = '0; o = 1'b0; il = 1'b0;
        d = x - y;
        case (op)
            4'b0000: r = x & y;
            4'b0001: r = x | y;
            4'b0010: begin r = x + y; o = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]); end
            4'b0110: begin r = d;     o = (x[W-1] != y[W-1]) && (d[W-1] != x[W-1]); end
            4'b0111: begin
                r = ($signed(x) < $signed(y)) ? W'(1) : W'(0);
                o = (x[W-1] != y[W-1]) && (d[W-1] != x[W-1]);
            end
            4'b1100: r = ~(x | y);
            default: il = 1'b1;
        endcase
        z = (r == '0);
    endtask

    // Issue one operation; edges counts from the accepting edge (inclusive) to
    // the first sample with done high. Operands are scrambled after accept.
    task automatic do_op(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                         output int edges, output logic busy_e0, output logic done_next,
                         output logic [W-1:0] r, output logic z, output logic o, output logic il);
        @(negedge clk);
        start = 1'b1; aluop = op; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0; a = $urandom; b = $urandom; aluop = 4'($urandom);
        busy_e0 = busy;
        edges = 1;
        while (!done && edges < 100) begin
            @(posedge clk); #1;
            edges++;
        end
        r = result; z = zero; o = overflow; il = illegal;
        @(posedge clk); #1;
        done_next = done;
    endtask

    initial begin
        int           edges, dcount;
        logic         be0, dn, z, o, il, ez, eo, eil;
        logic [W-1:0] r, er, held;
        logic [3:0]   ops[7];

        vecs[0] = '{4'b0010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{4'b0110, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{4'b1100, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{4'b0111, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{4'b0111, 32'h7FFFFFFF, 32'h80000000, 32'h00000000, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{4'b0000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{4'b0001, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{4'b1111, 32'hDEADBEEF, 32'h12345678, 32'h00000000, 1'b1, 1'b0, 1'b1};
        ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b1010};

        #12;
        check("reset_outputs", {26'b0, busy, done, zero, overflow, illegal, |result}, '0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, edges, be0, dn, r, z, o, il);
            check($sformatf("vec%0d_result", i), r, vecs[i].res);
            check($sformatf("vec%0d_flags", i), {29'b0, z, o, il}, {29'b0, vecs[i].z, vecs[i].ovf, vecs[i].ill});
            check($sformatf("vec%0d_latency", i), W'(edges), W'(W + 2));
            check($sformatf("vec%0d_busy_done_pulse", i), {30'b0, be0, dn}, {30'b0, 1'b1, 1'b0});
            check($sformatf("vec%0d_hold", i), result, vecs[i].res);
        end

        // Starts during RUN and during DONE are ignored.
        @(negedge clk);
        start = 1'b1; aluop = 4'b0010; a = 32'd1; b = 32'd2;
        @(posedge clk); #1;
        start = 1'b0; aluop = 4'b0110; a = 32'h55; b = 32'h11;
        dcount = 0; held = '0;
        for (int e = 1; e <= 80; e++) begin
            @(posedge clk); #1;
            if (done) begin dcount++; held = result; end
            start = (e == 5) || (e == 20) || done;
        end
        start = 1'b0;
        check("ignored_start_done_count", W'(dcount), W'(1));
        check("ignored_start_result", held, 32'd3);
        check("ignored_start_idle", {31'b0, busy}, '0);

        // Asynchronous reset in the middle of an ADD.
        @(negedge clk);
        start = 1'b1; aluop = 4'b0010; a = 32'h0000FFFF; b = 32'h00000001;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", {26'b0, busy, done, zero, overflow, illegal, |result}, '0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        dcount = 0;
        for (int e = 0; e < 40; e++) begin
            @(posedge clk); #1;
            if (done) dcount++;
        end
        check("async_reset_no_done", W'(dcount), '0);
        do_op(4'b0010, 32'h0000FFFF, 32'h00000001, edges, be0, dn, r, z, o, il);
        check("after_reset_result", r, 32'h00010000);
        check("after_reset_latency", W'(edges), W'(W + 2));

        // Randomized operations against the word-level model.
        for (int n = 0; n < 25; n++) begin
            logic [3:0]   op;
            logic [W-1:0] x, y;
            op = ops[$urandom_range(0, 6)];
            x  = $urandom;
            y  = ($urandom_range(0, 3) == 0) ? x : W'($urandom);
            if ($urandom_range(0, 4) == 0) x = {$urandom_range(0, 1) == 1, {(W-1){1'b1}}} ^ W'($urandom_range(0, 1));
            model(op, x, y, er, ez, eo, eil);
            do_op(op, x, y, edges, be0, dn, r, z, o, il);
            check($sformatf("rand%0d_op%h_result", n, op), r, er);
            check($sformatf("rand%0d_op%h_flags", n, op), {29'b0, z, o, il}, {29'b0, ez, eo, eil});
            check($sformatf("rand%0d_latency", n), W'(edges), W'(W + 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
